// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the byte-addressable data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {ST_CLEAR, ST_RUN} dm_state_t;

  function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: be_f = 4'b0001 << lane;
      SZ_HALF: be_f = 4'b0011 << {lane[1], 1'b0};
      SZ_WORD: be_f = 4'b1111;
      default: be_f = 4'b0000;
    endcase
  endfunction

  // raw holds the selected lane right-justified
  function automatic logic [31:0] sext_f(input logic [1:0] size, input logic sext,
                                         input logic [31:0] raw);
    case (size)
      SZ_BYTE: sext_f = {{24{sext & raw[7]}}, raw[7:0]};
      SZ_HALF: sext_f = {{16{sext & raw[15]}}, raw[15:0]};
      default: sext_f = raw;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: byte enables, store replication, load extraction and extension.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  always_comb begin
    be = be_f(size, lane);
    case (size)
      SZ_BYTE: wrep = {4{wdata[7:0]}};
      SZ_HALF: wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: shifted = rword >> {lane, 3'b000};
      SZ_HALF: shifted = rword >> {lane[1], 4'b0000};
      default: shifted = rword;
    endcase
    ldata = sext_f(size, sext, shifted);
  end

endmodule

// File: rtl/dm_byte_mem.sv
// MEM-stage data memory with sub-word access, error decode and a sequential clear engine.
//   state    | meaning
//   ST_CLEAR | zeroing RAM[clr_idx] each clock, busy=1, accesses blocked
//   ST_RUN   | normal load/store operation
module dm_byte_mem
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          TRACE     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  dm_state_t     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  logic [31:0]   off, old_word, wrep, ldata, mask, merged;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic          err_raw, store_ok;

  assign off      = addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign old_word = mem[idx];

  // Addresses below BASE_ADDR wrap to large offsets and land in the range error.
  always_comb begin
    err_raw = (off[31:AW+2] != '0)
           || (size == SZ_RSVD)
           || (size == SZ_HALF && off[0])
           || (size == SZ_WORD && off[1:0] != 2'b00);
  end

  dm_lane_unit u_lane (
    .size  (size),
    .lane  (off[1:0]),
    .sext  (sext),
    .wdata (wdata),
    .rword (old_word),
    .be    (be),
    .wrep  (wrep),
    .ldata (ldata)
  );

  assign mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged   = (old_word & ~mask) | (wrep & mask);
  assign busy     = (state_q == ST_CLEAR);
  assign addr_err = !busy && err_raw;
  assign rdata    = (busy || err_raw) ? 32'h0 : ldata;
  assign store_ok = we && !busy && !err_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (busy) mem[clr_idx_q] <= '0;
    else if (store_ok) mem[idx] <= merged;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (TRACE && store_ok) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: tb/tb_dm_byte_mem.sv
// Directed bench: a DEPTH=16 instance and a DEPTH=32 instance share the same stimulus.
module tb_dm_byte_mem;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, pc;
  logic        we, sext;
  logic [1:0]  size;
  logic [31:0] rd_a, rd_b;
  logic        err_a, err_b, busy_a, busy_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  dm_byte_mem #(.DEPTH(16), .BASE_ADDR(32'h0), .TRACE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .size(size),
    .sext(sext), .pc(pc), .rdata(rd_a), .addr_err(err_a), .busy(busy_a)
  );

  dm_byte_mem #(.DEPTH(32), .BASE_ADDR(32'h0), .TRACE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .size(size),
    .sext(sext), .pc(pc), .rdata(rd_b), .addr_err(err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input logic sx, input logic w);
    @(negedge clk);
    addr = a; wdata = d; size = sz; sext = sx; we = w;
    #1;
  endtask

  task automatic wait_clear(input string tag, input int exp_a, input int exp_b);
    int n_a, n_b;
    n_a = 0; n_b = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (n_a == 0 && !busy_a) begin n_a = c; we = 1'b0; end
      if (n_b == 0 && !busy_b) begin n_b = c; break; end
    end
    chk({tag, "_clocks_a"}, n_a, exp_a);
    chk({tag, "_clocks_b"}, n_b, exp_b);
  endtask

  initial begin
    int n_a, n_b;
    reset = 1'b1; addr = 0; wdata = 0; we = 0; size = W; sext = 0; pc = 32'h0040_0000;
    @(negedge clk); @(negedge clk);
    #1;
    chk("busy_in_reset", {31'b0, busy_a}, 32'h1);
    @(negedge clk);
    // store attempt held through the whole clear of dut_a
    addr = 32'h0; wdata = 32'hDEAD_BEEF; size = W; we = 1'b1;
    reset = 1'b0;
    n_a = 0; n_b = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        addr = 32'h41; #1;
        chk("busy_err_gated", {31'b0, err_a}, 32'h0);
        chk("busy_rdata_zero", rd_a, 32'h0);
        chk("busy_mid", {31'b0, busy_a}, 32'h1);
        addr = 32'h0;
      end
      if (n_a == 0 && !busy_a) begin n_a = c; we = 1'b0; end
      if (n_b == 0 && !busy_b) begin n_b = c; break; end
    end
    chk("clear_clocks_a", n_a, 16);
    chk("clear_clocks_b", n_b, 32);
    for (int i = 0; i < 16; i++) begin
      apply(32'(i * 4), 0, W, 0, 0);
      chk($sformatf("cleared_w%0d", i), rd_a, 32'h0);
    end

    pc = 32'h0040_0010;
    apply(32'h10, 32'h1122_3344, W, 0, 1);
    chk("sw10_err", {31'b0, err_a}, 32'h0);
    apply(32'h13, 0, B, 1, 0);  chk("lb13", rd_a, 32'h0000_0011);
    apply(32'h12, 0, H, 1, 0);  chk("lh12", rd_a, 32'h0000_1122);
    apply(32'h10, 0, B, 0, 0);  chk("lbu10", rd_a, 32'h0000_0044);
    apply(32'h10, 0, W, 1, 0);  chk("lw10", rd_a, 32'h1122_3344);

    pc = 32'h0040_0020;
    apply(32'h20, 32'hFFFF_FFFF, W, 0, 1);
    apply(32'h21, 32'h0000_005A, B, 0, 1);
    chk("sb21_old_lbu", rd_a, 32'h0000_00FF);
    apply(32'h20, 0, W, 0, 0);  chk("lw20", rd_a, 32'hFFFF_5AFF);
    apply(32'h22, 0, H, 0, 0);  chk("lhu22", rd_a, 32'h0000_FFFF);
    apply(32'h22, 0, H, 1, 0);  chk("lh22", rd_a, 32'hFFFF_FFFF);
    apply(32'h21, 0, B, 1, 0);  chk("lb21", rd_a, 32'h0000_005A);
    apply(32'h22, 32'h1234_8001, H, 0, 1);
    apply(32'h20, 0, W, 0, 0);  chk("lw20_sh", rd_a, 32'h8001_5AFF);
    apply(32'h22, 0, H, 1, 0);  chk("lh22_neg", rd_a, 32'hFFFF_8001);
    apply(32'h22, 0, H, 0, 0);  chk("lhu22_8001", rd_a, 32'h0000_8001);
    apply(32'h23, 0, B, 0, 0);  chk("lbu23", rd_a, 32'h0000_0080);
    apply(32'h23, 0, B, 1, 0);  chk("lb23", rd_a, 32'hFFFF_FF80);

    apply(32'h22, 32'hCAFE_BABE, W, 0, 1);
    chk("sw22_err", {31'b0, err_a}, 32'h1);
    chk("sw22_rdata", rd_a, 32'h0);
    apply(32'h23, 32'hCAFE_BABE, H, 0, 1);
    chk("sh23_err", {31'b0, err_a}, 32'h1);
    chk("sh23_rdata", rd_a, 32'h0);
    apply(32'h20, 32'hCAFE_BABE, R, 0, 1);
    chk("rsvd_err", {31'b0, err_a}, 32'h1);
    chk("rsvd_rdata", rd_a, 32'h0);
    apply(32'h20, 0, W, 0, 0);  chk("lw20_unchanged", rd_a, 32'h8001_5AFF);

    apply(32'h3C, 0, W, 0, 0);
    chk("last_word_err", {31'b0, err_a}, 32'h0);
    apply(32'h40, 0, W, 0, 0);
    chk("range_err_a", {31'b0, err_a}, 32'h1);
    chk("range_err_b", {31'b0, err_b}, 32'h0);
    chk("pre_lw40_b", rd_b, 32'h0);
    chk("range_rdata_a", rd_a, 32'h0);

    pc = 32'h0040_0040;
    apply(32'h40, 32'hA5A5_A5A5, W, 0, 1);
    chk("rbw_old_b", rd_b, 32'h0);
    apply(32'h40, 0, W, 0, 0);  chk("rbw_new_b", rd_b, 32'hA5A5_A5A5);
    apply(32'h00, 0, W, 0, 0);  chk("no_wrap_a", rd_a, 32'h0);
    apply(32'h80, 0, W, 0, 0);  chk("range_err_b80", {31'b0, err_b}, 32'h1);

    // restart the clear five clocks in
    @(negedge clk);
    reset = 1'b1; #1; reset = 1'b0;
    for (int c = 1; c <= 5; c++) @(posedge clk);
    #1;
    chk("busy_cycle5", {31'b0, busy_a}, 32'h1);
    reset = 1'b1; #2;
    chk("busy_in_pulse", {31'b0, busy_a}, 32'h1);
    reset = 1'b0;
    wait_clear("restart", 16, 32);
    apply(32'h10, 0, W, 0, 0);  chk("recleared_10", rd_a, 32'h0);
    apply(32'h20, 0, W, 0, 0);  chk("recleared_20", rd_a, 32'h0);
    apply(32'h40, 0, W, 0, 0);  chk("recleared_40_b", rd_b, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
